id_ex_alu_ctrl: RTL and testbench

- Decode-side producer of the execute-stage ALU control interface.
- Decodes a 32-bit RV32I instruction from the IF/ID register into the 4-bit aluOperation code and the 3-bit aluControl class, plus the operand-source selects.
- Registers all of these into the ID/EX pipeline register, with stall, flush and valid handling.
- Its outputs feed the execute-stage ALU and operand muxes directly.

---
 rtl/id_ex_alu_ctrl.sv | 162 ++++++++++++++++
 tb/tb_id_ex_alu_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_alu_ctrl.sv
// ID/EX producer for the execute-stage ALU control: decodes an RV32I word into
// operation/class/operand selects and registers them. Optional trap flag: ALU_CTRL_ILLEGAL_TRAP_EN.
module id_ex_alu_ctrl #(
    parameter logic [3:0] RESET_OP   = 4'd0,
    parameter logic [2:0] RESET_CTRL = 3'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic        stall,
    input  logic        flush,
    output logic [3:0]  aluOperation,
    output logic [2:0]  aluControl,
    output logic        use_imm,
    output logic        use_pc,
    output logic        ex_valid,
    output logic        illegal
);

    localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4,  OP_SLL  = 4'd5,  OP_SRL  = 4'd6,  OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8,  OP_SLTU = 4'd9,  OP_BEQ  = 4'd10, OP_BNE  = 4'd11;
    localparam logic [3:0] OP_BLT  = 4'd12, OP_BGE  = 4'd13, OP_BLTU = 4'd14, OP_BGEU = 4'd15;

    localparam logic [2:0] C_RTYPE = 3'd0, C_ITYPE = 3'd1, C_LDST  = 3'd2, C_BRANCH = 3'd3;
    localparam logic [2:0] C_JTYPE = 3'd4, C_JALR  = 3'd5, C_LUI   = 3'd6, C_AUIPC  = 3'd7;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Shared R/I arithmetic map; alt selects SUB/SRA.
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  arith_op = alt ? OP_SUB : OP_ADD;
            3'b001:  arith_op = OP_SLL;
            3'b010:  arith_op = OP_SLT;
            3'b011:  arith_op = OP_SLTU;
            3'b100:  arith_op = OP_XOR;
            3'b101:  arith_op = alt ? OP_SRA : OP_SRL;
            3'b110:  arith_op = OP_OR;
            default: arith_op = OP_AND;
        endcase
    endfunction

    logic       f7_legal;
    logic [3:0] dec_op;
    logic [2:0] dec_ctrl;
    logic       dec_imm;
    logic       dec_pc;
    logic       dec_ill;

    assign f7_legal = (funct7 == 7'b0000000) ||
                      ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

    always_comb begin
        dec_op   = RESET_OP;
        dec_ctrl = RESET_CTRL;
        dec_imm  = 1'b0;
        dec_pc   = 1'b0;
        dec_ill  = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec_op   = arith_op(funct3, funct7[5]);
                dec_ctrl = C_RTYPE;
                dec_ill  = !f7_legal;
            end
            7'b0010011: begin
                dec_op   = arith_op(funct3, (funct3 == 3'b101) && funct7[5]);
                dec_ctrl = C_ITYPE;
                dec_imm  = 1'b1;
                dec_ill  = ((funct3 == 3'b001) || (funct3 == 3'b101)) && !f7_legal;
            end
            7'b0000011, 7'b0100011: begin
                dec_op   = OP_ADD;
                dec_ctrl = C_LDST;
                dec_imm  = 1'b1;
            end
            7'b1100011: begin
                dec_ctrl = C_BRANCH;
                case (funct3)
                    3'b000:  dec_op = OP_BEQ;
                    3'b001:  dec_op = OP_BNE;
                    3'b100:  dec_op = OP_BLT;
                    3'b101:  dec_op = OP_BGE;
                    3'b110:  dec_op = OP_BLTU;
                    3'b111:  dec_op = OP_BGEU;
                    default: dec_ill = 1'b1;
                endcase
            end
            7'b1101111: begin
                dec_op   = OP_ADD;
                dec_ctrl = C_JTYPE;
                dec_imm  = 1'b1;
                dec_pc   = 1'b1;
            end
            7'b1100111: begin
                dec_op   = OP_ADD;
                dec_ctrl = C_JALR;
                dec_imm  = 1'b1;
                dec_ill  = (funct3 != 3'b000);
            end
            7'b0110111: begin
                dec_op   = OP_ADD;
                dec_ctrl = C_LUI;
                dec_imm  = 1'b1;
            end
            7'b0010111: begin
                dec_op   = OP_ADD;
                dec_ctrl = C_AUIPC;
                dec_imm  = 1'b1;
                dec_pc   = 1'b1;
            end
            default: dec_ill = 1'b1;
        endcase
        // Illegal encodings carry bubble control so EX never acts on them.
        if (dec_ill) begin
            dec_op   = RESET_OP;
            dec_ctrl = RESET_CTRL;
            dec_imm  = 1'b0;
            dec_pc   = 1'b0;
        end
    end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            aluOperation <= RESET_OP;
            aluControl   <= RESET_CTRL;
            use_imm      <= 1'b0;
            use_pc       <= 1'b0;
            ex_valid     <= 1'b0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            illegal_q    <= 1'b0;
`endif
        end else if (!stall) begin
            // instr_valid=0 loads a bubble regardless of the instruction bits.
            aluOperation <= instr_valid ? dec_op   : RESET_OP;
            aluControl   <= instr_valid ? dec_ctrl : RESET_CTRL;
            use_imm      <= instr_valid && dec_imm;
            use_pc       <= instr_valid && dec_pc;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            ex_valid     <= instr_valid;
            illegal_q    <= instr_valid && dec_ill;
`else
            ex_valid     <= instr_valid && !dec_ill;
`endif
        end
    end

endmodule

// File: tb/tb_id_ex_alu_ctrl.sv
// Table-driven bench for id_ex_alu_ctrl with a one-cycle expected-value queue.
module tb_id_ex_alu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        flush;
    logic [3:0]  aluOperation;
    logic [2:0]  aluControl;
    logic        use_imm;
    logic        use_pc;
    logic        ex_valid;
    logic        illegal;

    always #5 clk = ~clk;

    id_ex_alu_ctrl dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .stall(stall), .flush(flush), .aluOperation(aluOperation), .aluControl(aluControl),
        .use_imm(use_imm), .use_pc(use_pc), .ex_valid(ex_valid), .illegal(illegal)
    );

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        stall;
        logic        flush;
        logic [3:0]  op;
        logic [2:0]  ctrl;
        logic        imm;
        logic        pc;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [3:0] op;
        logic [2:0] ctrl;
        logic       imm;
        logic       pc;
        logic       exv;
        logic       ill;
    } out_t;

    vec_t vecs[$];
    out_t expq[$];
    out_t held;
    out_t bubble;
    int   checks = 0;
    int   errors = 0;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    task automatic add(input logic [31:0] i, input logic v, input logic s, input logic f,
                       input logic [3:0] op, input logic [2:0] ctrl,
                       input logic imm, input logic pc, input logic ill);
        vec_t e;
        e.instr = i; e.valid = v; e.stall = s; e.flush = f;
        e.op = op; e.ctrl = ctrl; e.imm = imm; e.pc = pc; e.ill = ill;
        vecs.push_back(e);
    endtask

    function automatic out_t expect_of(input vec_t v, input logic rst, input out_t prev);
        out_t o;
        o = bubble;
        if (rst || v.flush)      o = bubble;
        else if (v.stall)        o = prev;
        else if (!v.valid)       o = bubble;
        else if (v.ill) begin
            o.exv = TRAP;
            o.ill = TRAP;
        end else begin
            o.op = v.op; o.ctrl = v.ctrl; o.imm = v.imm; o.pc = v.pc; o.exv = 1'b1;
        end
        return o;
    endfunction

    task automatic apply(input vec_t v, input logic rst, input string name);
        out_t e, got;
        instr = v.instr; instr_valid = v.valid; stall = v.stall; flush = v.flush; reset = rst;
        e = expect_of(v, rst, held);
        held = e;
        expq.push_back(e);
        @(posedge clk);
        #1;
        got.op = aluOperation; got.ctrl = aluControl; got.imm = use_imm;
        got.pc = use_pc; got.exv = ex_valid; got.ill = illegal;
        if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = expq.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got op=%0d ctrl=%0d imm=%0b pc=%0b exv=%0b ill=%0b, expected op=%0d ctrl=%0d imm=%0b pc=%0b exv=%0b ill=%0b",
                         name, got.op, got.ctrl, got.imm, got.pc, got.exv, got.ill,
                         e.op, e.ctrl, e.imm, e.pc, e.exv, e.ill);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        bubble = '{op: 4'd0, ctrl: 3'd0, imm: 1'b0, pc: 1'b0, exv: 1'b0, ill: 1'b0};
        held = bubble;
        //   instr         vld stl fl  op     ctrl  imm pc  ill
        add(32'h003100B3, 1, 0, 0, 4'd0,  3'd0, 0, 0, 0); // add
        add(32'h403100B3, 1, 0, 0, 4'd1,  3'd0, 0, 0, 0); // sub
        add(32'h40315093, 1, 0, 0, 4'd7,  3'd1, 1, 0, 0); // srai
        add(32'h00208063, 1, 0, 0, 4'd10, 3'd3, 0, 0, 0); // beq
        add(32'h00008067, 1, 0, 0, 4'd0,  3'd5, 1, 0, 0); // jalr
        add(32'h403100B3, 1, 0, 0, 4'd1,  3'd0, 0, 0, 0); // sub, then stall x3
        add(32'h00208063, 1, 1, 0, 4'd10, 3'd3, 0, 0, 0);
        add(32'h00208063, 1, 1, 0, 4'd10, 3'd3, 0, 0, 0);
        add(32'h00208063, 1, 1, 0, 4'd10, 3'd3, 0, 0, 0);
        add(32'h00208063, 1, 0, 0, 4'd10, 3'd3, 0, 0, 0);
        add(32'h003100B3, 1, 1, 1, 4'd0,  3'd0, 0, 0, 0); // stall+flush
        add(32'h003100B3, 1, 0, 1, 4'd0,  3'd0, 0, 0, 0); // flush alone
        add(32'h00000000, 1, 0, 0, 4'd0,  3'd0, 0, 0, 1); // illegal opcode
        add(32'h00000000, 1, 1, 0, 4'd0,  3'd0, 0, 0, 1); // stall holds illegal
        add(32'h003150B3, 1, 0, 0, 4'd6,  3'd0, 0, 0, 0); // srl
        add(32'h403100B3, 0, 0, 0, 4'd1,  3'd0, 0, 0, 0); // invalid -> bubble
        add(32'h003110B3, 1, 0, 0, 4'd5,  3'd0, 0, 0, 0); // sll
        add(32'h003120B3, 1, 0, 0, 4'd8,  3'd0, 0, 0, 0); // slt
        add(32'h003130B3, 1, 0, 0, 4'd9,  3'd0, 0, 0, 0); // sltu
        add(32'h003140B3, 1, 0, 0, 4'd4,  3'd0, 0, 0, 0); // xor
        add(32'h003160B3, 1, 0, 0, 4'd3,  3'd0, 0, 0, 0); // or
        add(32'h003170B3, 1, 0, 0, 4'd2,  3'd0, 0, 0, 0); // and
        add(32'h403140B3, 1, 0, 0, 4'd0,  3'd0, 0, 0, 1); // xor with alt funct7
        add(32'h0FF17093, 1, 0, 0, 4'd2,  3'd1, 1, 0, 0); // andi
        add(32'hFFF10093, 1, 0, 0, 4'd0,  3'd1, 1, 0, 0); // addi, imm bits ignored
        add(32'h00311093, 1, 0, 0, 4'd5,  3'd1, 1, 0, 0); // slli
        add(32'h40311093, 1, 0, 0, 4'd0,  3'd0, 0, 0, 1); // slli with alt funct7
        add(32'h00315093, 1, 0, 0, 4'd6,  3'd1, 1, 0, 0); // srli
        add(32'h00012083, 1, 0, 0, 4'd0,  3'd2, 1, 0, 0); // lw
        add(32'h00112023, 1, 0, 0, 4'd0,  3'd2, 1, 0, 0); // sw
        add(32'h00209063, 1, 0, 0, 4'd11, 3'd3, 0, 0, 0); // bne
        add(32'h0020C063, 1, 0, 0, 4'd12, 3'd3, 0, 0, 0); // blt
        add(32'h0020D063, 1, 0, 0, 4'd13, 3'd3, 0, 0, 0); // bge
        add(32'h0020E063, 1, 0, 0, 4'd14, 3'd3, 0, 0, 0); // bltu
        add(32'h0020F063, 1, 0, 0, 4'd15, 3'd3, 0, 0, 0); // bgeu
        add(32'h0020A063, 1, 0, 0, 4'd0,  3'd0, 0, 0, 1); // branch funct3 010
        add(32'h0000006F, 1, 0, 0, 4'd0,  3'd4, 1, 1, 0); // jal
        add(32'h00009067, 1, 0, 0, 4'd0,  3'd0, 0, 0, 1); // jalr funct3 001
        add(32'h123450B7, 1, 0, 0, 4'd0,  3'd6, 1, 0, 0); // lui
        add(32'h00001097, 1, 0, 0, 4'd0,  3'd7, 1, 1, 0); // auipc

        // Reset held two cycles.
        v = vecs[0];
        apply(v, 1'b1, "reset_cycle0");
        apply(v, 1'b1, "reset_cycle1");

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], 1'b0, $sformatf("vec%0d_%08h", i, vecs[i].instr));

        // Reset during a stall discards held contents; later stall keeps the reset state.
        apply(vecs[1], 1'b0, "pre_rst_sub");
        v = vecs[1]; v.stall = 1'b1;
        apply(v, 1'b1, "reset_mid_stall");
        apply(v, 1'b0, "stall_after_reset");
        apply(vecs[38], 1'b0, "lui_after_stall");

        if (expq.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
